pipe_stage_skid_unit: RTL and testbench

- Parametrised, generic pipeline-boundary register for the seven-stage core. Intended to replace hand-written per-stage pipe units such as fetch→decode and decode→execute.
- Carries an opaque payload bus with a valid/ready handshake.
- A 2-entry skid buffer keeps the upstream ready signal registered, so no combinational stall path crosses the stage.
- Supports flush (bubble insertion after branch/jump redirect) and saturating stall/bubble performance counters.

---
 rtl/core_pipe_pkg.sv | 33 +++
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_stage_skid_unit.sv | 116 +++++++++++
 tb/tb_pipe_stage_skid_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_pkg.sv
// Shared definitions for the core pipeline-boundary registers: NOP encoding,
// skid-stage state encoding and per-stage payload field offsets.
package core_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // fetch->decode bundle: {pc, instr}
    localparam int IF_ID_INSTR_LSB = 0;
    localparam int IF_ID_INSTR_W   = 32;
    localparam int IF_ID_PC_LSB    = IF_ID_INSTR_LSB + IF_ID_INSTR_W;
    localparam int IF_ID_PC_W      = 32;
    localparam int IF_ID_W         = IF_ID_PC_LSB + IF_ID_PC_W;

    // decode->execute bundle: {ctrl, imm, rs2, rs1, rd}
    localparam int ID_EX_RD_LSB    = 0;
    localparam int ID_EX_RD_W      = 5;
    localparam int ID_EX_RS1_LSB   = ID_EX_RD_LSB + ID_EX_RD_W;
    localparam int ID_EX_RS1_W     = 5;
    localparam int ID_EX_RS2_LSB   = ID_EX_RS1_LSB + ID_EX_RS1_W;
    localparam int ID_EX_RS2_W     = 5;
    localparam int ID_EX_IMM_LSB   = ID_EX_RS2_LSB + ID_EX_RS2_W;
    localparam int ID_EX_IMM_W     = 32;
    localparam int ID_EX_CTRL_LSB  = ID_EX_IMM_LSB + ID_EX_IMM_W;
    localparam int ID_EX_CTRL_W    = 16;
    localparam int ID_EX_W         = ID_EX_CTRL_LSB + ID_EX_CTRL_W;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and a clear that beats increment.
module sat_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {COUNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid_unit.sv
// Generic pipeline-boundary register: valid/ready handshake with a 2-entry skid
// buffer so ready_out is a flop, plus flush and stall/bubble counters.
module pipe_stage_skid_unit
    import core_pipe_pkg::*;
#(
    parameter int                       PAYLOAD_WIDTH = 32,
    parameter logic [PAYLOAD_WIDTH-1:0] NOP_PAYLOAD   = PAYLOAD_WIDTH'(NOP_INSTR),
    parameter int                       COUNT_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [PAYLOAD_WIDTH-1:0] payload_in,
    output logic                     ready_out,
    output logic                     valid_out,
    output logic [PAYLOAD_WIDTH-1:0] payload_out,
    input  logic                     ready_in,
    input  logic                     flush,
    input  logic                     clear_counters,
    output logic [COUNT_WIDTH-1:0]   stall_count,
    output logic [COUNT_WIDTH-1:0]   bubble_count
);

    pipe_state_e              r_state;
    pipe_state_e              w_state_nxt;
    logic                     r_ready;
    logic [PAYLOAD_WIDTH-1:0] r_main_d;
    logic [PAYLOAD_WIDTH-1:0] r_skid_d;
    logic [PAYLOAD_WIDTH-1:0] w_main_nxt;
    logic                     w_main_load;
    logic                     w_skid_load;
    logic                     w_main_v;
    logic                     w_accept;
    logic                     w_drain;

    assign w_main_v = (r_state != EMPTY);
    assign w_accept = valid_in & r_ready;
    assign w_drain  = w_main_v & ready_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_ready  <= 1'b1;
            r_main_d <= NOP_PAYLOAD;
            r_skid_d <= NOP_PAYLOAD;
        end else begin
            r_state <= w_state_nxt;
            // ready is precomputed from the next state so no upstream path is combinational
            r_ready <= (w_state_nxt != SKID);
            if (w_main_load) r_main_d <= w_main_nxt;
            if (w_skid_load) r_skid_d <= payload_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = payload_in;
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = FULL;
                    w_main_load = 1'b1;
                end
            end
            FULL: begin
                if (w_drain && w_accept) begin
                    w_main_load = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = EMPTY;
                end else if (w_accept) begin
                    w_state_nxt = SKID;
                    w_skid_load = 1'b1;
                end
            end
            SKID: begin
                if (w_drain) begin
                    w_state_nxt = FULL;
                    w_main_nxt  = r_skid_d;
                    w_main_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    assign ready_out   = r_ready;
    assign valid_out   = w_main_v;
    assign payload_out = w_main_v ? r_main_d : NOP_PAYLOAD;

    // counters sample pre-edge state and ignore flush
    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_counters),
        .inc   (w_main_v & ~ready_in),
        .count (stall_count)
    );

    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear_counters),
        .inc   (~w_main_v),
        .count (bubble_count)
    );

endmodule

// File: tb/tb_pipe_stage_skid_unit.sv
// Directed bench for pipe_stage_skid_unit: streaming, skid capture, flush,
// stall hold, counter saturation and mid-stream reset.
module tb_pipe_stage_skid_unit;

    localparam int PW = 32;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          valid_in;
    logic [PW-1:0] payload_in;
    logic          ready_out;
    logic          valid_out;
    logic [PW-1:0] payload_out;
    logic          ready_in;
    logic          flush;
    logic          clear_counters;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] bubble_count;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid_unit #(
        .PAYLOAD_WIDTH (PW),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_in       (valid_in),
        .payload_in     (payload_in),
        .ready_out      (ready_out),
        .valid_out      (valid_out),
        .payload_out    (payload_out),
        .ready_in       (ready_in),
        .flush          (flush),
        .clear_counters (clear_counters),
        .stall_count    (stall_count),
        .bubble_count   (bubble_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; payload_in = '0; ready_in = 1'b1;
        flush = 1'b0; clear_counters = 1'b0;
        tick(); tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        checks++; if (payload_out !== 32'h13) begin errors++; $display("FAIL reset_payload: got %h want 00000013", payload_out); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
        checks++; if (bubble_count !== 4'd0) begin errors++; $display("FAIL reset_bubble: got %0d want 0", bubble_count); end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        valid_in = 1'b1; ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            payload_in = i;
            tick();
            checks++; if (payload_out !== i) begin errors++; $display("FAIL stream_payload[%0d]: got %h want %h", i, payload_out, i); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, valid_out); end
            checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, ready_out); end
        end
        valid_in = 1'b0;
        checks++; if (bubble_count !== 4'd1) begin errors++; $display("FAIL stream_bubble: got %0d want 1", bubble_count); end
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", valid_out); end
        checks++; if (payload_out !== 32'h13) begin errors++; $display("FAIL stream_drain_payload: got %h want 00000013", payload_out); end
        checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL stream_stall: got %0d want 0", stall_count); end
    endtask

    task automatic test_skid_capture();
        valid_in = 1'b1; ready_in = 1'b1; payload_in = 32'hA;
        tick();
        checks++; if (payload_out !== 32'hA) begin errors++; $display("FAIL skid_first: got %h want a", payload_out); end
        payload_in = 32'hB; ready_in = 1'b0;
        tick();
        checks++; if (payload_out !== 32'hA) begin errors++; $display("FAIL skid_hold_a: got %h want a", payload_out); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL skid_ready_low: got %b want 0", ready_out); end
        payload_in = 32'hC;
        tick();
        checks++; if (payload_out !== 32'hA) begin errors++; $display("FAIL skid_hold_a2: got %h want a", payload_out); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL skid_ready_low2: got %b want 0", ready_out); end
        ready_in = 1'b1;
        tick();
        checks++; if (payload_out !== 32'hB) begin errors++; $display("FAIL skid_release_b: got %h want b", payload_out); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b want 1", ready_out); end
        tick();
        checks++; if (payload_out !== 32'hC) begin errors++; $display("FAIL skid_release_c: got %h want c", payload_out); end
        valid_in = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL skid_empty: got %b want 0", valid_out); end
    endtask

    task automatic test_flush_skid();
        valid_in = 1'b1; ready_in = 1'b1; payload_in = 32'h11;
        tick();
        ready_in = 1'b0; payload_in = 32'h22;
        tick();
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL flush_pre_skid: got ready %b want 0", ready_out); end
        flush = 1'b1; payload_in = 32'h55;
        tick();
        flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid_out); end
        checks++; if (payload_out !== 32'h13) begin errors++; $display("FAIL flush_payload: got %h want 00000013", payload_out); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", ready_out); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (valid_out !== 1'b0 || payload_out === 32'h55) begin errors++; $display("FAIL flush_no_55[%0d]: got valid %b payload %h want 0/00000013", i, valid_out, payload_out); end
        end
    endtask

    task automatic test_stall_hold();
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        valid_in = 1'b1; ready_in = 1'b1; payload_in = 32'hDEAD;
        tick();
        valid_in = 1'b0; ready_in = 1'b0; payload_in = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (payload_out !== 32'hDEAD || valid_out !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got valid %b payload %h want 1/0000dead", i, valid_out, payload_out); end
        end
        checks++; if (stall_count !== 4'd5) begin errors++; $display("FAIL stall_count: got %0d want 5", stall_count); end
        ready_in = 1'b1;
        tick();
        checks++; if (stall_count !== 4'd5) begin errors++; $display("FAIL stall_count_after: got %0d want 5", stall_count); end
        checks++; if (bubble_count !== 4'd1) begin errors++; $display("FAIL stall_bubble: got %0d want 1", bubble_count); end
    endtask

    task automatic test_counter_saturation();
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        checks++; if (bubble_count !== 4'd0) begin errors++; $display("FAIL sat_cleared: got %0d want 0", bubble_count); end
        for (int i = 0; i < 20; i++) tick();
        checks++; if (bubble_count !== 4'd15) begin errors++; $display("FAIL sat_bubble: got %0d want 15", bubble_count); end
        tick(); tick();
        checks++; if (bubble_count !== 4'd15) begin errors++; $display("FAIL sat_bubble_hold: got %0d want 15", bubble_count); end
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        checks++; if (bubble_count !== 4'd0) begin errors++; $display("FAIL sat_clear_beats_inc: got %0d want 0", bubble_count); end
        tick();
        checks++; if (bubble_count !== 4'd1) begin errors++; $display("FAIL sat_restart: got %0d want 1", bubble_count); end
    endtask

    task automatic test_reset_midstream();
        valid_in = 1'b1; ready_in = 1'b1; payload_in = 32'h77;
        tick();
        valid_in = 1'b0; ready_in = 1'b0;
        tick();
        checks++; if (stall_count === 4'd0 || valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre: got stall %0d valid %b want nonzero/1", stall_count, valid_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0; ready_in = 1'b1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid_out); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ready_out); end
        checks++; if (payload_out !== 32'h13) begin errors++; $display("FAIL mid_payload: got %h want 00000013", payload_out); end
        checks++; if (stall_count !== 4'd0 || bubble_count !== 4'd0) begin errors++; $display("FAIL mid_counters: got %0d/%0d want 0/0", stall_count, bubble_count); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid_capture();
        test_flush_skid();
        test_stall_hold();
        test_counter_saturation();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
